// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction memory, hazard controls,
// decode redirects and the IF/ID register outputs.
interface if_stage_if;
    // Instruction memory
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [5:0]  instr_code_in;

    // Hazard unit
    logic        stall;
    logic        flush;

    // Redirects resolved in decode
    logic [31:0] id_pc;
    logic        branch_in;
    logic [31:0] branch_addr;
    logic        jump_in;
    logic [25:0] jump_addr;
    logic        jump_reg_in;
    logic [31:0] jump_reg_addr;

    // IF/ID register
    logic [31:0] pc_out;
    logic [31:0] instructure_out;
    logic [5:0]  instr_code_out;
    logic        valid_out;

    modport master (
        output imem_addr,
        input  imem_data,
        input  instr_code_in,
        input  stall,
        input  flush,
        input  id_pc,
        input  branch_in,
        input  branch_addr,
        input  jump_in,
        input  jump_addr,
        input  jump_reg_in,
        input  jump_reg_addr,
        output pc_out,
        output instructure_out,
        output instr_code_out,
        output valid_out
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output instr_code_in,
        output stall,
        output flush,
        output id_pc,
        output branch_in,
        output branch_addr,
        output jump_in,
        output jump_addr,
        output jump_reg_in,
        output jump_reg_addr,
        input  pc_out,
        input  instructure_out,
        input  instr_code_out,
        input  valid_out
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Delayed-branch ISA: the delay slot is never squashed here.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  code;
        logic        valid;
    } if_id_t;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] seq_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] br_off;
    logic [31:0] br_pc;
    logic [31:0] j_pc;

    if_id_t if_id_q;
    if_id_t if_id_d;

    // Redirect targets are relative to the instruction in decode.
    assign seq_pc      = pc + 32'd4;
    assign id_pc_plus4 = bus.id_pc + 32'd4;
    assign br_off      = bus.branch_addr << 2;
    assign br_pc       = id_pc_plus4 + br_off;
    assign j_pc        = {id_pc_plus4[31:28], bus.jump_addr, 2'b00};

    // Next-PC select: jr beats j beats branch beats sequential.
    always_comb begin
        next_pc = seq_pc;
        priority case (1'b1)
            bus.jump_reg_in: next_pc = bus.jump_reg_addr;
            bus.jump_in:     next_pc = j_pc;
            bus.branch_in:   next_pc = br_pc;
            default:         next_pc = seq_pc;
        endcase
    end

    // IF/ID payload: the fetched word, or a bubble on flush.
    always_comb begin
        if_id_d.pc    = pc;
        if_id_d.instr = bus.imem_data;
        if_id_d.code  = bus.instr_code_in;
        if_id_d.valid = 1'b1;
        if (bus.flush) begin
            if_id_d.instr = 32'h0;
            if_id_d.code  = 6'h0;
            if_id_d.valid = 1'b0;
        end
    end

    // PC and IF/ID update; stall freezes both and beats flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            if_id_q.pc    <= RESET_PC;
            if_id_q.instr <= 32'h0;
            if_id_q.code  <= 6'h0;
            if_id_q.valid <= 1'b0;
        end else if (!bus.stall) begin
            pc      <= next_pc;
            if_id_q <= if_id_d;
        end
    end

    assign bus.imem_addr       = pc;
    assign bus.pc_out          = if_id_q.pc;
    assign bus.instructure_out = if_id_q.instr;
    assign bus.instr_code_out  = if_id_q.code;
    assign bus.valid_out       = if_id_q.valid;

endmodule
